// File: rtl/m8_buf_writer.sv
// m8_buf_writer
//   Ping-pong buffer writer feeding the M8 telemetry frame generator. Incoming
//   12-bit samples are written into the half of a 2 x 2^ADDR_W word dual-port
//   RAM that the generator is not reading. The generator's bank toggle selects
//   the half it reads, and the writer always fills the other half.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-low
//   iSwitch    bank toggle from the generator; generator reads bank iSwitch
//   iData      sample word
//   iValid     one-cycle strobe qualifying iData
//   oWrEn      RAM write enable (one cycle per accepted sample)
//   oWrAddr    RAM write address {bank, word}
//   oWrData    RAM write data
//   oReady     writer is accepting samples (FILL)
//   oFull      current bank completely written (DONE)
//   oFillCnt   words written into the current bank, 0..2^ADDR_W
//   oDropCnt   samples discarded while DONE, saturating
//   oShortCnt  toggles that arrived before the bank was full, saturating
//   oShort     one-cycle pulse on each short fill
//
// All outputs come straight from flops. ADDR_W must be at least 1.

module m8_buf_writer #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iSwitch,
    input  logic [11:0]       iData,
    input  logic              iValid,
    output logic              oWrEn,
    output logic [ADDR_W:0]   oWrAddr,
    output logic [11:0]       oWrData,
    output logic              oReady,
    output logic              oFull,
    output logic [ADDR_W:0]   oFillCnt,
    output logic [CNT_W-1:0]  oDropCnt,
    output logic [CNT_W-1:0]  oShortCnt,
    output logic              oShort
);

    typedef enum logic {
        FILL = 1'b0,
        DONE = 1'b1
    } stateT;

    localparam logic [ADDR_W:0]  LAST_WORD = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    stateT             state;
    stateT             stateNext;
    logic              swPrev;
    logic              wrBank;
    logic              wrBankNext;
    logic              toggle;

    logic              wrEnNext;
    logic [ADDR_W:0]   wrAddrNext;
    logic [11:0]       wrDataNext;
    logic [ADDR_W:0]   fillCntNext;
    logic [CNT_W-1:0]  dropCntNext;
    logic [CNT_W-1:0]  shortCntNext;
    logic              shortNext;

    // oFillCnt doubles as the next word address while filling: in FILL it is
    // always below 2^ADDR_W, so its low ADDR_W bits are the address.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves one unassigned, which would infer a latch.
        toggle       = iSwitch ^ swPrev;
        stateNext    = state;
        wrBankNext   = wrBank;
        wrEnNext     = 1'b0;
        wrAddrNext   = oWrAddr;
        wrDataNext   = oWrData;
        fillCntNext  = oFillCnt;
        dropCntNext  = oDropCnt;
        shortCntNext = oShortCnt;
        shortNext    = 1'b0;

        if (toggle) begin
            // Toggle wins over everything: restart at word 0 of the new bank.
            wrBankNext  = ~iSwitch;
            stateNext   = FILL;
            wrAddrNext  = {~iSwitch, {ADDR_W{1'b0}}};
            fillCntNext = '0;
            if (state == FILL) begin
                shortNext = 1'b1;
                if (oShortCnt != CNT_MAX) begin
                    shortCntNext = oShortCnt + 1'b1;
                end
            end
            // A sample arriving with the toggle lands at word 0 of the new bank.
            if (iValid) begin
                wrEnNext    = 1'b1;
                wrDataNext  = iData;
                fillCntNext = {{ADDR_W{1'b0}}, 1'b1};
            end
        end else if (iValid) begin
            if (state == FILL) begin
                wrEnNext    = 1'b1;
                wrAddrNext  = {wrBank, oFillCnt[ADDR_W-1:0]};
                wrDataNext  = iData;
                fillCntNext = oFillCnt + 1'b1;
                if (oFillCnt == LAST_WORD) begin
                    stateNext = DONE;
                end
            end else if (oDropCnt != CNT_MAX) begin
                dropCntNext = oDropCnt + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // swPrev follows iSwitch during reset so release never looks
            // like a toggle.
            swPrev    <= iSwitch;
            wrBank    <= ~iSwitch;
            state     <= FILL;
            oWrEn     <= 1'b0;
            oWrAddr   <= {~iSwitch, {ADDR_W{1'b0}}};
            oWrData   <= '0;
            oReady    <= 1'b1;
            oFull     <= 1'b0;
            oFillCnt  <= '0;
            oDropCnt  <= '0;
            oShortCnt <= '0;
            oShort    <= 1'b0;
        end else begin
            swPrev    <= iSwitch;
            wrBank    <= wrBankNext;
            state     <= stateNext;
            oWrEn     <= wrEnNext;
            oWrAddr   <= wrAddrNext;
            oWrData   <= wrDataNext;
            oReady    <= (stateNext == FILL);
            oFull     <= (stateNext == DONE);
            oFillCnt  <= fillCntNext;
            oDropCnt  <= dropCntNext;
            oShortCnt <= shortCntNext;
            oShort    <= shortNext;
        end
    end

endmodule

// File: tb/tb_m8_buf_writer.sv
// tb_m8_buf_writer
//   Self-checking bench for m8_buf_writer. A count-based reference model
//   predicts every output each cycle; a vector table and directed sequences
//   cover the corner cases; a behavioural RAM stands in for the dual-port
//   memory so the generator side can read back whole banks.

`timescale 1ns/1ps

module tb_m8_buf_writer;

    localparam int ADDR_W  = 10;
    localparam int CNT_W   = 8;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              iSwitch;
    logic [11:0]       iData;
    logic              iValid;
    logic              oWrEn;
    logic [ADDR_W:0]   oWrAddr;
    logic [11:0]       oWrData;
    logic              oReady;
    logic              oFull;
    logic [ADDR_W:0]   oFillCnt;
    logic [CNT_W-1:0]  oDropCnt;
    logic [CNT_W-1:0]  oShortCnt;
    logic              oShort;

    m8_buf_writer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .iSwitch   (iSwitch),
        .iData     (iData),
        .iValid    (iValid),
        .oWrEn     (oWrEn),
        .oWrAddr   (oWrAddr),
        .oWrData   (oWrData),
        .oReady    (oReady),
        .oFull     (oFull),
        .oFillCnt  (oFillCnt),
        .oDropCnt  (oDropCnt),
        .oShortCnt (oShortCnt),
        .oShort    (oShort)
    );

    always #40 clk = ~clk;

    // Dual-port RAM stand-in written by the DUT, read by the generator model.
    logic [11:0] ram [0:2*DEPTH-1];
    always @(posedge clk) begin
        if (oWrEn) ram[oWrAddr] <= oWrData;
    end

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int shortSeen = 0;
    int wrSeen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: tracks how many words the current bank holds and
    // derives full/ready/drop/short from that count.
    int          mCount, mDrop, mShortCnt, eWrAddr;
    bit          mBank, mPrevSw, eWrEn, eShort;
    logic [11:0] eWrData;

    task automatic modelStep();
        bit tog;
        eWrEn  = 1'b0;
        eShort = 1'b0;
        if (!reset) begin
            mPrevSw   = iSwitch;
            mBank     = !iSwitch;
            mCount    = 0;
            mDrop     = 0;
            mShortCnt = 0;
            eWrAddr   = int'(mBank) * DEPTH;
            eWrData   = '0;
            return;
        end
        tog     = (iSwitch != mPrevSw);
        mPrevSw = iSwitch;
        if (tog) begin
            if (mCount < DEPTH) begin
                eShort = 1'b1;
                if (mShortCnt < CNT_MAX) mShortCnt++;
            end
            mBank   = !iSwitch;
            mCount  = 0;
            eWrAddr = int'(mBank) * DEPTH;
        end
        if (iValid) begin
            if (mCount < DEPTH) begin
                eWrEn   = 1'b1;
                eWrAddr = int'(mBank) * DEPTH + mCount;
                eWrData = iData;
                mCount++;
            end else if (mDrop < CNT_MAX) begin
                mDrop++;
            end
        end
    endtask

    function automatic logic [63:0] expBundle();
        return {10'b0, eWrEn, 11'(eWrAddr), eWrData, (mCount < DEPTH), (mCount == DEPTH),
                11'(mCount), 8'(mDrop), 8'(mShortCnt), eShort};
    endfunction

    function automatic logic [63:0] dutBundle();
        return {10'b0, oWrEn, oWrAddr, oWrData, oReady, oFull, oFillCnt, oDropCnt, oShortCnt, oShort};
    endfunction

    // One clock: model consumes the current inputs, DUT outputs are compared
    // 1 ns after the edge.
    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
        cycle++;
        check($sformatf("cycle %0d", cycle), dutBundle(), expBundle());
        if (oShort) shortSeen++;
        if (oWrEn)  wrSeen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic doReset();
        reset  = 1'b0;
        iValid = 1'b0;
        tick();
        reset  = 1'b1;
    endtask

    task automatic sample(input logic [11:0] d);
        iValid = 1'b1;
        iData  = d;
        tick();
        iValid = 1'b0;
    endtask

    typedef struct {
        logic        sw;
        logic        valid;
        logic [11:0] data;
        logic        wrEn;
        logic [10:0] wrAddr;
        logic [11:0] wrData;
        logic [10:0] fillCnt;
        logic [7:0]  shortCnt;
        logic        shortP;
    } vecT;

    vecT vecs [9];

    logic [11:0] blk [DEPTH];

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int mism;
        int wrBefore;
        int shortBefore;
        int seq;
        localparam int G    = 4;
        localparam int HALF = DEPTH * G;

        reset   = 1'b0;
        iSwitch = 1'b0;
        iValid  = 1'b0;
        iData   = '0;

        // Reset state
        doReset();
        check("rst_wren",   oWrEn,     0);
        check("rst_wraddr", oWrAddr,   1024);
        check("rst_wrdata", oWrData,   0);
        check("rst_ready",  oReady,    1);
        check("rst_full",   oFull,     0);
        check("rst_fill",   oFillCnt,  0);
        check("rst_drop",   oDropCnt,  0);
        check("rst_short",  {oShortCnt, oShort}, 0);

        // Vector table: toggles, write addressing, toggle+valid, zero-fill short
        vecs[0] = '{1'b0, 1'b1, 12'h111, 1'b1, 11'd1024, 12'h111, 11'd1, 8'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 12'h000, 1'b0, 11'd1024, 12'h111, 11'd1, 8'd0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 12'h222, 1'b1, 11'd1025, 12'h222, 11'd2, 8'd0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 12'h000, 1'b0, 11'd0,    12'h222, 11'd0, 8'd1, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 12'h333, 1'b1, 11'd0,    12'h333, 11'd1, 8'd1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 12'hABC, 1'b1, 11'd1024, 12'hABC, 11'd1, 8'd2, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 12'h000, 1'b0, 11'd1024, 12'hABC, 11'd1, 8'd2, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 12'h000, 1'b0, 11'd0,    12'hABC, 11'd0, 8'd3, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 12'h000, 1'b0, 11'd1024, 12'hABC, 11'd0, 8'd4, 1'b1};
        doReset();
        for (int i = 0; i < 9; i++) begin
            iSwitch = vecs[i].sw;
            iValid  = vecs[i].valid;
            iData   = vecs[i].data;
            tick();
            check($sformatf("vec %0d", i),
                  {oWrEn, oWrAddr, oWrData, oFillCnt, oShortCnt, oShort},
                  {vecs[i].wrEn, vecs[i].wrAddr, vecs[i].wrData, vecs[i].fillCnt,
                   vecs[i].shortCnt, vecs[i].shortP});
        end
        iValid = 1'b0;

        // Nominal fill into bank 1
        iSwitch = 1'b0;
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            sample(12'(i));
            idle(2);
        end
        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[DEPTH + i] !== 12'(i)) mism++;
        check("nominal_data_mismatches", mism, 0);
        check("nominal_full",  oFull,    1);
        check("nominal_ready", oReady,   0);
        check("nominal_fill",  oFillCnt, 1024);

        // Overrun and drop-counter saturation
        wrBefore = wrSeen;
        for (int i = 0; i < 5; i++) begin
            sample(12'h5A5);
            idle(1);
        end
        check("overrun_no_write", wrSeen - wrBefore, 0);
        check("overrun_drop5", oDropCnt, 5);
        for (int i = 0; i < 300; i++) sample(12'(i));
        check("overrun_drop_sat", oDropCnt, 255);
        check("overrun_fill_held", oFillCnt, 1024);

        // Short fill: 100 samples then toggle
        iSwitch = 1'b0;
        doReset();
        for (int i = 0; i < 100; i++) begin
            sample(12'(i));
            idle(1);
        end
        iSwitch = 1'b1;
        tick();
        check("short_pulse",  oShort,    1);
        check("short_count",  oShortCnt, 1);
        tick();
        check("short_pulse_end", oShort, 0);
        sample(12'h055);
        check("short_next_addr", oWrAddr,  0);
        check("short_next_fill", oFillCnt, 1);
        check("short_next_wren", oWrEn,    1);
        idle(1);

        // Toggle and iValid together while filling
        iSwitch = 1'b0;
        sample(12'hABC);
        check("simul_addr",  oWrAddr,   1024);
        check("simul_data",  oWrData,   12'hABC);
        check("simul_short", oShortCnt, 2);
        check("simul_drop",  oDropCnt,  0);
        check("simul_fill",  oFillCnt,  1);
        idle(1);

        // Reset mid-fill with iSwitch=1
        iSwitch = 1'b1;
        tick();
        for (int i = 0; i < 500; i++) sample(12'(i + 7));
        check("midfill_count", oFillCnt, 500);
        shortBefore = shortSeen;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_counters", {oFillCnt, oDropCnt, oShortCnt}, 0);
        check("midrst_ready", oReady, 1);
        sample(12'h123);
        check("midrst_first_addr", oWrAddr, 0);
        check("midrst_first_wren", oWrEn,   1);
        idle(3);
        check("midrst_no_short", shortSeen - shortBefore, 0);

        // Closed loop with the generator: 8 half-periods, 1024 samples each
        iSwitch = 1'b0;
        doReset();
        seq = 0;
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < HALF; c++) begin
                if (c == 0 && p > 0) begin
                    iSwitch = logic'(p % 2);
                    mism = 0;
                    for (int i = 0; i < DEPTH; i++)
                        if (ram[(p % 2) * DEPTH + i] !== blk[i]) mism++;
                    check($sformatf("loop_block %0d", p - 1), mism, 0);
                end
                iValid = (c % G == 0);
                if (iValid) begin
                    iData = 12'(seq);
                    blk[c / G] = 12'(seq);
                    seq++;
                end
                tick();
            end
        end
        iValid  = 1'b0;
        iSwitch = 1'b0;
        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== blk[i]) mism++;
        check("loop_block 7", mism, 0);
        tick();
        check("loop_short", oShortCnt, 0);
        check("loop_drop",  oDropCnt,  0);

        // Randomized stimulus against the model
        iSwitch = 1'b0;
        doReset();
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 2999) != 0);
            if ($urandom_range(0, 1499) == 0) iSwitch = ~iSwitch;
            iValid = ($urandom_range(0, 3) != 0);
            iData  = 12'($urandom);
            tick();
        end
        reset  = 1'b1;
        iValid = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/m8_buf_writer.md
# m8_buf_writer

Ping-pong buffer writer that sits directly upstream of the M8 telemetry frame generator. It takes a stream of 12-bit samples with a valid strobe and writes them into the half of a 2×1024-word dual-port RAM that the M8 generator is not currently reading. It follows the generator's bank-switch toggle to change halves. It reports fill state, dropped samples and incomplete fills.

## Interface
Parameters:
- ADDR_W, 10, word-address width of one bank (bank depth = 2^ADDR_W)
- CNT_W, 8, width of the saturating error counters

Ports:
- clk  in  1  system clock, 12 582 912 Hz
- reset  in  1  synchronous, active-low
- iSwitch  in  1  bank toggle from the M8 generator; generator reads bank iSwitch
- iData  in  12  sample word
- iValid  in  1  one-cycle strobe, iData valid
- oWrEn  out  1  RAM write enable
- oWrAddr  out  ADDR_W+1  {bank, word address}
- oWrData  out  12  RAM write data
- oReady  out  1  writer accepts samples (state FILL)
- oFull  out  1  current bank completely written (state DONE)
- oFillCnt  out  ADDR_W+1  words written into current bank, 0..2^ADDR_W
- oDropCnt  out  CNT_W  samples discarded while DONE, saturating
- oShortCnt  out  CNT_W  toggles that arrived before bank was full, saturating
- oShort  out  1  one-cycle pulse on each short fill

## Operation
- Toggle detect: register swPrev <= iSwitch every cycle; toggle = iSwitch ^ swPrev. During reset, swPrev loads iSwitch, so no toggle fires on reset release.
- Write bank is always ~iSwitch as sampled on the toggle cycle. It is held in register wrBank and does not change between toggles.
- States:
  - FILL: accepting samples.
  - DONE: bank full, samples dropped.
- No IDLE state. Reset enters FILL with wrBank = ~iSwitch and address 0.
- FILL, iValid, no toggle: write iData at {wrBank, addr}, addr++, oFillCnt++. The write of address 2^ADDR_W−1 moves to DONE.
- DONE, iValid, no toggle: no write; oDropCnt++ (saturates at 2^CNT_W−1).
- Toggle, any state:
  - wrBank <= ~iSwitch, addr <= 0, oFillCnt <= 0, state <= FILL.
  - If the old state was FILL, oShort pulses and oShortCnt++ (saturating). A toggle at fill count 0 also counts as short.
- Toggle and iValid in the same cycle: the toggle takes priority. The sample is written to address 0 of the new bank, and oFillCnt becomes 1. If the old state was FILL, the short is still counted, and the sample is not counted as dropped.
- Address wraps only through toggle. The counter never wraps past the bank end on its own.
- Reset mid-fill: all state is cleared and fill restarts at address 0 of ~iSwitch. The partially written bank is abandoned and no short is counted.

## Timing
- All outputs are registered.
- Write latency: iValid in cycle n gives oWrEn=1 in cycle n+1, with oWrAddr/oWrData for that sample. oWrEn is high for exactly one cycle per accepted sample.
- oFillCnt, oReady and oFull update in cycle n+1, aligned with oWrEn.
- Toggle in cycle n:
  - new wrBank is visible on oWrAddr MSB from n+1;
  - oShort is high in n+1 only;
  - oReady=1 and oFull=0 from n+1.
- Back-to-back iValid every cycle is supported. The M8 generator consumes one word per 96 clocks, so the sustained input rate is at most one sample per 96 clocks.
- Reset values: oWrEn=0, oWrAddr={~iSwitch,0}, oWrData=0, oReady=1, oFull=0, oFillCnt=0, oDropCnt=0, oShortCnt=0, oShort=0.

## Test plan
- Nominal fill: iSwitch=0, 1024 samples 0..1023, one per 96 clocks.
  - Writes go to addresses 1024..2047 with data equal to the index.
  - After the last write, oFull=1, oReady=0 and oFillCnt=1024.
- Overrun: after the bank is full, 5 more iValid.
  - No oWrEn.
  - oDropCnt=5.
  - Saturation: 300 extra samples give oDropCnt=255.
- Short fill: 100 samples, then iSwitch toggles 0→1.
  - oShort is a one-cycle pulse and oShortCnt=1.
  - The next sample is written to address 0 (bank 0), and oFillCnt=1.
- Simultaneous toggle and iValid with data 12'hABC while in FILL.
  - oWrAddr=0 in the new bank, oWrData=12'hABC.
  - oShortCnt increments; oDropCnt is unchanged.
- Reset mid-fill at word 500 with iSwitch=1.
  - All counters are 0 and oReady=1.
  - The first post-reset sample is written to address 0.
  - No oShort pulse.
- Closed loop with the M8 generator: 4 full bank cycles.
  - Each M8 read block returns exactly the 1024 samples written during the previous half-period.
  - oShortCnt=0 and oDropCnt=0 when the source rate is matched.
